// File: rtl/data_mem_responder.sv
// Byte-serial data-memory responder: on-chip byte RAM plus an 8-byte MMIO window
// (TX FIFO, status, GPIO, snapshot-on-read cycle counter).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module data_mem_responder #(
  parameter int unsigned RAM_BYTES  = 1024,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [31:0]            i_mem_addr,
  input  logic                   i_mem_write,
  input  logic [`DATA_WIDTH-1:0] i_mem_data,
  output logic [`DATA_WIDTH-1:0] o_mem_data,
  output logic                   o_fault,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic [7:0]             o_gpio
);

  localparam int unsigned AW = $clog2(RAM_BYTES);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {
    REG_TXDATA = 3'd0,
    REG_STATUS = 3'd1,
    REG_GPIO   = 3'd2,
    REG_RSVD   = 3'd3,
    REG_CYC3   = 3'd4,
    REG_CYC2   = 3'd5,
    REG_CYC1   = 3'd6,
    REG_CYC0   = 3'd7
  } mmio_reg_e;

  // Address decode
  logic            in_ram;
  logic            in_mmio;
  logic            mmio_wr;
  logic            mmio_rd;
  mmio_reg_e       mmio_reg;
  logic [AW-1:0]   ram_addr;
  logic [7:0]      wr_byte;

  // State
  logic [7:0]      ram_q [RAM_BYTES];
  logic [7:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      gpio_q, gpio_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     snap_q, snap_d;

  // Control
  logic            ram_we;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push_req;
  logic            push;
  logic            pop;
  logic [7:0]      rd_byte;

  always_comb begin
    in_ram   = (i_mem_addr < 32'(RAM_BYTES));
    in_mmio  = (i_mem_addr[31:3] == MMIO_BASE[31:3]);
    mmio_wr  = in_mmio && i_mem_write;
    mmio_rd  = in_mmio && !i_mem_write;
    mmio_reg = mmio_reg_e'(i_mem_addr[2:0]);
    ram_addr = i_mem_addr[AW-1:0];
    wr_byte  = i_mem_data[7:0];
    o_fault  = !in_ram && !in_mmio;
    ram_we   = in_ram && i_mem_write;
  end

  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      ram_q[ram_addr] <= wr_byte;
    end
  end

  // TX FIFO control: a pop frees a slot in the same cycle, so a full FIFO
  // still accepts a push while the consumer is draining.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    pop        = !fifo_empty && i_tx_ready;
    push_req   = mmio_wr && (mmio_reg == REG_TXDATA);
    push       = push_req && (!fifo_full || pop);

    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);

    ovf_d = ovf_q;
    if (push_req && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end else if (mmio_wr && (mmio_reg == REG_STATUS) && wr_byte[2]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem_q[wptr_q] <= wr_byte;
    end
  end

  // GPIO, cycle counter and snapshot
  always_comb begin
    gpio_d = gpio_q;
    if (mmio_wr && (mmio_reg == REG_GPIO)) begin
      gpio_d = wr_byte;
    end

    cnt_d = cnt_q + 32'd1;

    // Reading the MSB latches the whole live count so bytes 1-3 of a
    // 4-byte load come from the same instant and cannot be torn by a carry.
    snap_d = snap_q;
    if (mmio_rd && (mmio_reg == REG_CYC3)) begin
      snap_d = cnt_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      gpio_q  <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      gpio_q  <= gpio_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
    end
  end

  // Read mux
  always_comb begin
    rd_byte = '0;
    if (in_ram) begin
      rd_byte = ram_q[ram_addr];
    end else if (in_mmio) begin
      case (mmio_reg)
        REG_STATUS: rd_byte = {5'b0, ovf_q, fifo_full, fifo_empty};
        REG_GPIO:   rd_byte = gpio_q;
        REG_CYC3:   rd_byte = cnt_q[31:24];
        REG_CYC2:   rd_byte = snap_q[23:16];
        REG_CYC1:   rd_byte = snap_q[15:8];
        REG_CYC0:   rd_byte = snap_q[7:0];
        default:    rd_byte = '0;
      endcase
    end
    o_mem_data      = '0;
    o_mem_data[7:0] = rd_byte;
  end

  // Storage has no reset, so the head byte is masked to zero while empty.
  always_comb begin
    o_tx_valid = !fifo_empty;
    o_tx_data  = fifo_empty ? 8'h00 : fifo_mem_q[rptr_q];
    o_gpio     = gpio_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of bus vectors plus hand-written
// FIFO, counter-snapshot and asynchronous-reset sequences.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_data_mem_responder;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic                   clk;
  logic                   rst_n;
  logic [31:0]            addr;
  logic                   we;
  logic [`DATA_WIDTH-1:0] wdata;
  logic [`DATA_WIDTH-1:0] rdata;
  logic                   fault;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [7:0]             gpio;

  int tests;
  int fails;

  data_mem_responder #(
    .RAM_BYTES (1024),
    .FIFO_DEPTH(4),
    .MMIO_BASE (32'hFFFF_0000)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_mem_addr (addr),
    .i_mem_write(we),
    .i_mem_data (wdata),
    .o_mem_data (rdata),
    .o_fault    (fault),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_gpio     (gpio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [7:0]  d;
    logic        chk_data;
    logic [7:0]  exp_data;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    addr = a; we = 1'b1; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [7:0] exp);
    addr = a; we = 1'b0;
    #1;
    chk(name, 32'(rdata), 32'(exp));
    @(negedge clk);
  endtask

  task automatic add(input logic [31:0] a, input logic w, input logic [7:0] d,
                     input logic cd, input logic [7:0] ed, input logic ef);
    vec_t v;
    v.a = a; v.w = w; v.d = d; v.chk_data = cd; v.exp_data = ed; v.exp_fault = ef;
    vecs.push_back(v);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; addr = '0; we = 1'b0; wdata = '0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_gpio", 32'(gpio), 32'h00);
    chk("reset_tx_valid", 32'(tx_valid), 32'h0);
    chk("reset_tx_data", 32'(tx_data), 32'h00);
    rst_n = 1'b1;
    @(negedge clk);

    add(32'h0000_0000, 1, 8'h11, 0, 8'h00, 0);
    add(32'h0000_0010, 1, 8'hA5, 0, 8'h00, 0);
    add(32'h0000_0010, 0, 8'h00, 1, 8'hA5, 0);
    add(32'h0000_0020, 1, 8'h12, 0, 8'h00, 0);
    add(32'h0000_0021, 1, 8'h34, 0, 8'h00, 0);
    add(32'h0000_0022, 1, 8'h56, 0, 8'h00, 0);
    add(32'h0000_0023, 1, 8'h78, 0, 8'h00, 0);
    add(32'h0000_0020, 0, 8'h00, 1, 8'h12, 0);
    add(32'h0000_0021, 0, 8'h00, 1, 8'h34, 0);
    add(32'h0000_0022, 0, 8'h00, 1, 8'h56, 0);
    add(32'h0000_0023, 0, 8'h00, 1, 8'h78, 0);
    add(32'h8000_0000, 0, 8'h00, 1, 8'h00, 1);
    add(32'h8000_0000, 1, 8'hEE, 1, 8'h00, 1);
    add(32'h0000_0000, 0, 8'h00, 1, 8'h11, 0);
    add(32'h0000_0400, 0, 8'h00, 1, 8'h00, 1);
    add(32'h0000_03FF, 1, 8'h99, 0, 8'h00, 0);
    add(32'h0000_03FF, 0, 8'h00, 1, 8'h99, 0);
    add(MB + 32'd1,    0, 8'h00, 1, 8'h01, 0);
    add(MB + 32'd5,    0, 8'h00, 1, 8'h00, 0);
    add(MB + 32'd7,    0, 8'h00, 1, 8'h00, 0);
    add(MB + 32'd2,    1, 8'h3C, 0, 8'h00, 0);
    add(MB + 32'd2,    0, 8'h00, 1, 8'h3C, 0);
    add(MB + 32'd3,    1, 8'h55, 0, 8'h00, 0);
    add(MB + 32'd3,    0, 8'h00, 1, 8'h00, 0);
    add(MB + 32'd8,    0, 8'h00, 1, 8'h00, 1);
    add(MB - 32'd1,    0, 8'h00, 1, 8'h00, 1);
    add(MB,            0, 8'h00, 1, 8'h00, 0);

    foreach (vecs[i]) begin
      addr = vecs[i].a; we = vecs[i].w; wdata = vecs[i].d;
      #1;
      chk($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].exp_fault));
      if (vecs[i].chk_data)
        chk($sformatf("vec%0d_data", i), 32'(rdata), 32'(vecs[i].exp_data));
      @(negedge clk);
    end
    we = 1'b0;
    chk("gpio_out", 32'(gpio), 32'h3C);

    // TX overflow then drain
    tx_ready = 1'b0;
    wr(MB, 8'hA1);
    #1;
    chk("tx_valid_after_push", 32'(tx_valid), 32'h1);
    chk("tx_head_a1", 32'(tx_data), 32'hA1);
    wr(MB, 8'hA2);
    wr(MB, 8'hA3);
    wr(MB, 8'hA4);
    wr(MB, 8'hA5);
    rd("status_full_ovf", MB + 32'd1, 8'h06);
    addr = 32'h0000_0100; tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain%0d_valid", i), 32'(tx_valid), 32'h1);
      chk($sformatf("drain%0d_data", i), 32'(tx_data), 32'(8'hA1 + 8'(i)));
      @(negedge clk);
    end
    #1;
    chk("drain_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    @(negedge clk);
    rd("status_ovf_empty", MB + 32'd1, 8'h05);
    wr(MB + 32'd1, 8'h04);
    rd("status_cleared", MB + 32'd1, 8'h01);

    // Push into a full FIFO while it pops in the same cycle
    wr(MB, 8'hB1);
    wr(MB, 8'hB2);
    wr(MB, 8'hB3);
    wr(MB, 8'hB4);
    rd("status_full", MB + 32'd1, 8'h02);
    tx_ready = 1'b1;
    addr = MB; we = 1'b1; wdata = 8'h77;
    #1;
    chk("pp_head_b1", 32'(tx_data), 32'hB1);
    @(negedge clk);
    we = 1'b0; addr = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("pp%0d_data", i), 32'(tx_data), 32'(i == 3 ? 8'h77 : 8'hB2 + 8'(i)));
      @(negedge clk);
    end
    #1;
    chk("pp_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    rd("pp_status_no_ovf", MB + 32'd1, 8'h01);

    // Counter snapshot across the carry into bit 24
    addr = MB + 32'd4; we = 1'b0;
    force dut.cnt_q = 32'h00FF_FFFF;
    #1;
    chk("cyc_b0", 32'(rdata), 32'h00);
    release dut.cnt_q;
    @(negedge clk);
    rd("cyc_b1", MB + 32'd5, 8'hFF);
    rd("cyc_b2", MB + 32'd6, 8'hFF);
    rd("cyc_b3", MB + 32'd7, 8'hFF);
    rd("cyc_live_msb", MB + 32'd4, 8'h01);

    // Asynchronous reset mid-cycle with a queued byte
    wr(MB, 8'h5A);
    #1;
    chk("pre_reset_valid", 32'(tx_valid), 32'h1);
    chk("pre_reset_gpio", 32'(gpio), 32'h3C);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gpio", 32'(gpio), 32'h00);
    chk("async_rst_valid", 32'(tx_valid), 32'h0);
    chk("async_rst_data", 32'(tx_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd("post_rst_status", MB + 32'd1, 8'h01);
    rd("post_rst_snap", MB + 32'd6, 8'h00);
    rd("ram_keep_10", 32'h0000_0010, 8'hA5);
    rd("ram_keep_20", 32'h0000_0020, 8'h12);
    rd("ram_keep_21", 32'h0000_0021, 8'h34);
    rd("ram_keep_22", 32'h0000_0022, 8'h56);
    rd("ram_keep_23", 32'h0000_0023, 8'h78);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
